// File: rtl/div16_if.sv
// Handshake and data bundle between a division requester and div16_controller.
// The master drives the request and operands; the slave returns status and results.
interface div16_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             shift_left_enable_q;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  ready,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero,
    input  shift_left_enable_q
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output ready,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero,
    output shift_left_enable_q
  );

endinterface

// File: rtl/div16_controller.sv
// Sequential unsigned divider using the non-restoring algorithm, one quotient
// bit per clock. A zero divisor short-circuits straight to DONE with all-ones
// quotient and the dividend as remainder. All status outputs are registered
// and follow the FSM state: ready in IDLE, busy in ITER/FIX, done in DONE.
module div16_controller #(
  parameter int WIDTH = 16
) (
  input logic   clk,
  input logic   rst,
  div16_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state;

  // The partial remainder carries one extra bit so its sign is visible and
  // the shifted value never overflows for any unsigned operand pair.
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   a_step;
  logic [WIDTH:0]   a_fix;

  assign m_ext   = {1'b0, m_reg};
  assign a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign a_step  = a_reg[WIDTH] ? (a_shift + m_ext) : (a_shift - m_ext);
  assign a_fix   = a_reg[WIDTH] ? (a_reg + m_ext) : a_reg;

  // Single FSM block: state, datapath registers and registered outputs together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      a_reg                   <= '0;
      q_reg                   <= '0;
      m_reg                   <= '0;
      count                   <= '0;
      bus.quotient            <= '0;
      bus.remainder           <= '0;
      bus.div_by_zero         <= 1'b0;
      bus.done                <= 1'b0;
      bus.busy                <= 1'b0;
      bus.shift_left_enable_q <= 1'b0;
      bus.ready               <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_reg           <= '0;
            q_reg           <= bus.dividend;
            m_reg           <= bus.divisor;
            count           <= COUNT_INIT;
            bus.div_by_zero <= 1'b0;
            bus.ready       <= 1'b0;
            if (bus.divisor == '0) begin
              bus.quotient            <= '1;
              bus.remainder           <= bus.dividend;
              bus.div_by_zero         <= 1'b1;
              bus.done                <= 1'b1;
              bus.busy                <= 1'b0;
              bus.shift_left_enable_q <= 1'b0;
              state                   <= DONE;
            end else begin
              bus.busy                <= 1'b1;
              bus.shift_left_enable_q <= 1'b1;
              state                   <= ITER;
            end
          end
        end

        ITER: begin
          a_reg <= a_step;
          q_reg <= {q_reg[WIDTH-2:0], ~a_step[WIDTH]};
          count <= count - COUNT_ONE;
          if (count == COUNT_ONE) begin
            bus.shift_left_enable_q <= 1'b0;
            state                   <= FIX;
          end
        end

        FIX: begin
          a_reg         <= a_fix;
          bus.quotient  <= q_reg;
          bus.remainder <= a_fix[WIDTH-1:0];
          bus.busy      <= 1'b0;
          bus.done      <= 1'b1;
          state         <= DONE;
        end

        DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          bus.done                <= 1'b0;
          bus.busy                <= 1'b0;
          bus.shift_left_enable_q <= 1'b0;
          bus.ready               <= 1'b1;
          state                   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div16_controller.sv
// Directed bench for div16_controller: each task drives one scenario and
// compares the observed outputs against hand-computed values.
module tb_div16_controller;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div16_if #(.WIDTH(16)) bus ();

  div16_controller #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Launches one request and follows it to done, returning what was observed.
  // Cycle 1 is the cycle right after the accept edge. lat stays 0 on timeout.
  // When poke is set, extra start pulses with other operands are driven in
  // cycles 3..10 while the divider is busy.
  task automatic run_op(input logic [15:0] dd, input logic [15:0] ds, input bit poke,
                        output int lat, output logic [15:0] q, output logic [15:0] r,
                        output logic dbz, output int shl_cnt, output int busy_cnt);
    int n;
    n = 0;
    while (!bus.ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = ds;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 16'hA5A5;
    bus.divisor  = 16'h0003;
    lat      = 0;
    shl_cnt  = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.shift_left_enable_q) shl_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
      if (poke && c >= 2 && c <= 9) begin
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    q   = bus.quotient;
    r   = bus.remainder;
    dbz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.quotient !== 16'd0) begin failures++; $display("[TB] FAIL reset_quotient got=%0d exp=0", bus.quotient); end
    checks++; if (bus.remainder !== 16'd0) begin failures++; $display("[TB] FAIL reset_remainder got=%0d exp=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    checks++; if (bus.shift_left_enable_q !== 1'b0) begin failures++; $display("[TB] FAIL reset_shl got=%b exp=0", bus.shift_left_enable_q); end
  endtask

  task automatic test_basic();
    int lat, shl, bsy;
    logic [15:0] q, r;
    logic dbz;
    run_op(16'd100, 16'd7, 1'b0, lat, q, r, dbz, shl, bsy);
    checks++; if (lat !== 18) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=18", lat); end
    checks++; if (q !== 16'd14) begin failures++; $display("[TB] FAIL basic_quotient got=%0d exp=14", q); end
    checks++; if (r !== 16'd2) begin failures++; $display("[TB] FAIL basic_remainder got=%0d exp=2", r); end
    checks++; if (dbz !== 1'b0) begin failures++; $display("[TB] FAIL basic_dbz got=%b exp=0", dbz); end
    checks++; if (bsy !== 17) begin failures++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=17", bsy); end
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_pulse got=%b exp=0", bus.done); end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready_after got=%b exp=1", bus.ready); end
    checks++; if (bus.quotient !== 16'd14) begin failures++; $display("[TB] FAIL basic_quotient_hold got=%0d exp=14", bus.quotient); end
  endtask

  task automatic test_max_operands();
    int lat, shl, bsy;
    logic [15:0] q, r;
    logic dbz;
    run_op(16'hFFFF, 16'd1, 1'b0, lat, q, r, dbz, shl, bsy);
    checks++; if (q !== 16'hFFFF) begin failures++; $display("[TB] FAIL max_div1_quotient got=%0d exp=65535", q); end
    checks++; if (r !== 16'd0) begin failures++; $display("[TB] FAIL max_div1_remainder got=%0d exp=0", r); end
    run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, q, r, dbz, shl, bsy);
    checks++; if (q !== 16'd1) begin failures++; $display("[TB] FAIL max_same_quotient got=%0d exp=1", q); end
    checks++; if (r !== 16'd0) begin failures++; $display("[TB] FAIL max_same_remainder got=%0d exp=0", r); end
    run_op(16'd65534, 16'd65535, 1'b0, lat, q, r, dbz, shl, bsy);
    checks++; if (q !== 16'd0) begin failures++; $display("[TB] FAIL max_near_quotient got=%0d exp=0", q); end
    checks++; if (r !== 16'd65534) begin failures++; $display("[TB] FAIL max_near_remainder got=%0d exp=65534", r); end
  endtask

  task automatic test_small_dividend();
    int lat, shl, bsy;
    logic [15:0] q, r;
    logic dbz;
    run_op(16'd3, 16'd10, 1'b0, lat, q, r, dbz, shl, bsy);
    checks++; if (q !== 16'd0) begin failures++; $display("[TB] FAIL small_quotient got=%0d exp=0", q); end
    checks++; if (r !== 16'd3) begin failures++; $display("[TB] FAIL small_remainder got=%0d exp=3", r); end
    checks++; if (shl !== 16) begin failures++; $display("[TB] FAIL small_shift_cycles got=%0d exp=16", shl); end
  endtask

  task automatic test_div_zero();
    int lat, shl, bsy;
    logic [15:0] q, r;
    logic dbz;
    run_op(16'd5, 16'd0, 1'b0, lat, q, r, dbz, shl, bsy);
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL dz_latency got=%0d exp=1", lat); end
    checks++; if (q !== 16'hFFFF) begin failures++; $display("[TB] FAIL dz_quotient got=%0h exp=ffff", q); end
    checks++; if (r !== 16'd5) begin failures++; $display("[TB] FAIL dz_remainder got=%0d exp=5", r); end
    checks++; if (dbz !== 1'b1) begin failures++; $display("[TB] FAIL dz_flag got=%b exp=1", dbz); end
    checks++; if (bsy !== 0) begin failures++; $display("[TB] FAIL dz_busy_cycles got=%0d exp=0", bsy); end
    @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL dz_ready_after got=%b exp=1", bus.ready); end
    checks++; if (bus.div_by_zero !== 1'b1) begin failures++; $display("[TB] FAIL dz_flag_hold got=%b exp=1", bus.div_by_zero); end
  endtask

  task automatic test_reset_mid_op();
    int lat, shl, bsy;
    logic [15:0] q, r;
    logic dbz;
    bit done_seen;
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd3;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL rm_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL rm_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rm_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.quotient !== 16'd0) begin failures++; $display("[TB] FAIL rm_quotient got=%0d exp=0", bus.quotient); end
    checks++; if (bus.remainder !== 16'd0) begin failures++; $display("[TB] FAIL rm_remainder got=%0d exp=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL rm_dbz got=%b exp=0", bus.div_by_zero); end
    checks++; if (bus.shift_left_enable_q !== 1'b0) begin failures++; $display("[TB] FAIL rm_shl got=%b exp=0", bus.shift_left_enable_q); end
    done_seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen = 1'b1;
    end
    checks++; if (done_seen !== 1'b0) begin failures++; $display("[TB] FAIL rm_no_done got=%b exp=0", done_seen); end
    run_op(16'd200, 16'd9, 1'b0, lat, q, r, dbz, shl, bsy);
    checks++; if (q !== 16'd22) begin failures++; $display("[TB] FAIL rm_next_quotient got=%0d exp=22", q); end
    checks++; if (r !== 16'd2) begin failures++; $display("[TB] FAIL rm_next_remainder got=%0d exp=2", r); end
  endtask

  task automatic test_start_while_busy();
    int lat, shl, bsy;
    logic [15:0] q, r;
    logic dbz;
    run_op(16'd1000, 16'd7, 1'b1, lat, q, r, dbz, shl, bsy);
    checks++; if (lat !== 18) begin failures++; $display("[TB] FAIL swb_latency got=%0d exp=18", lat); end
    checks++; if (q !== 16'd142) begin failures++; $display("[TB] FAIL swb_quotient got=%0d exp=142", q); end
    checks++; if (r !== 16'd6) begin failures++; $display("[TB] FAIL swb_remainder got=%0d exp=6", r); end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL swb_no_queue got=%b exp=1", bus.ready); end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int nacc;
    int n;
    bit prev_ready;
    nacc = 0;
    acc[0] = 0;
    acc[1] = 0;
    bus.dividend = 16'd50;
    bus.divisor  = 16'd5;
    bus.start    = 1'b1;
    prev_ready   = bus.ready;
    for (int c = 1; c <= 60 && nacc < 2; c++) begin
      @(posedge clk);
      #1;
      if (prev_ready && bus.busy) begin
        acc[nacc] = c;
        nacc++;
      end
      prev_ready = bus.ready;
    end
    bus.start = 1'b0;
    checks++; if (nacc !== 2) begin failures++; $display("[TB] FAIL b2b_accepts got=%0d exp=2", nacc); end
    checks++; if (acc[1] - acc[0] !== 19) begin failures++; $display("[TB] FAIL b2b_spacing got=%0d exp=19", acc[1] - acc[0]); end
    n = 0;
    while (!bus.done && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done got=%b exp=1", bus.done); end
    checks++; if (bus.quotient !== 16'd10) begin failures++; $display("[TB] FAIL b2b_quotient got=%0d exp=10", bus.quotient); end
    checks++; if (bus.remainder !== 16'd0) begin failures++; $display("[TB] FAIL b2b_remainder got=%0d exp=0", bus.remainder); end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 16'd0;
    test_reset();
    test_basic();
    test_max_operands();
    test_small_dividend();
    test_div_zero();
    test_reset_mid_op();
    test_start_while_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
